// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: icache miss handler that picks a victim way, fetches the line and fills it
module icache_refill_fsm #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int NUM_SET    = 4,
  parameter int NUM_WAYS   = 4,
  localparam int OFFSET_BITS = $clog2(LINE_BYTES),
  localparam int SET_BITS    = $clog2(NUM_SET),
  localparam int WAY_BITS    = $clog2(NUM_WAYS),
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - SET_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    miss_valid,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  output logic                    miss_ready,
  input  logic [NUM_WAYS-1:0]     set_valid_mask,
  output logic                    victim_req,
  output logic [SET_BITS-1:0]     victim_set,
  input  logic [WAY_BITS-1:0]     victim_way,
  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_rsp_data,
  output logic                    fill_valid,
  output logic [SET_BITS-1:0]     fill_set,
  output logic [WAY_BITS-1:0]     fill_way,
  output logic [TAG_BITS-1:0]     fill_tag,
  output logic [LINE_BYTES*8-1:0] fill_data,
  output logic                    update_req,
  output logic [SET_BITS-1:0]     update_set,
  output logic [WAY_BITS-1:0]     update_way,
  output logic                    busy
);
  typedef enum logic [2:0] {IDLE, VICTIM, MEM_REQ, MEM_WAIT, FILL} state_t;
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [WAY_BITS-1:0]     way;
  logic [LINE_BYTES*8-1:0] data;
  logic [WAY_BITS-1:0]     inv_way;
  logic [SET_BITS-1:0]     set;
  logic [TAG_BITS-1:0]     tag;
  assign set = addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
  assign tag = addr[ADDR_WIDTH-1:OFFSET_BITS+SET_BITS];
  // descending scan so the lowest-index invalid way wins
  always_comb begin
    inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      inv_way = set_valid_mask[i] ? inv_way : WAY_BITS'(i);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr  <= '0;
      way   <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: if (miss_valid) begin
          addr  <= miss_addr;
          state <= VICTIM;
        end
        VICTIM: begin
          way   <= &set_valid_mask ? victim_way : inv_way;
          state <= MEM_REQ;
        end
        MEM_REQ: if (mem_req_ready) state <= MEM_WAIT;
        MEM_WAIT: if (mem_rsp_valid) begin
          data  <= mem_rsp_data;
          state <= FILL;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign miss_ready    = state == IDLE;
  assign busy          = state != IDLE;
  assign victim_req    = state == VICTIM;
  assign victim_set    = victim_req ? set : '0;
  assign mem_req_valid = state == MEM_REQ;
  assign mem_req_addr  = mem_req_valid ? addr & ~ADDR_WIDTH'(LINE_BYTES - 1) : '0;
  assign fill_valid    = state == FILL;
  assign fill_set      = fill_valid ? set : '0;
  assign fill_way      = fill_valid ? way : '0;
  assign fill_tag      = fill_valid ? tag : '0;
  assign fill_data     = fill_valid ? data : '0;
  assign update_req    = fill_valid;
  assign update_set    = fill_set;
  assign update_way    = fill_way;
endmodule

// File: tb/tb_icache_refill_fsm.sv
// tb_icache_refill_fsm: directed refill scenarios with a queue-based scoreboard monitor
module tb_icache_refill_fsm;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic [3:0]   set_valid_mask = '0;
  logic         victim_req;
  logic [1:0]   victim_set;
  logic [1:0]   victim_way = '0;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0;
  logic         mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_data = '0;
  logic         fill_valid;
  logic [1:0]   fill_set;
  logic [1:0]   fill_way;
  logic [25:0]  fill_tag;
  logic [127:0] fill_data;
  logic         update_req;
  logic [1:0]   update_set;
  logic [1:0]   update_way;
  logic         busy;

  icache_refill_fsm dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .set_valid_mask(set_valid_mask), .victim_req(victim_req), .victim_set(victim_set),
    .victim_way(victim_way), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag),
    .fill_data(fill_data), .update_req(update_req), .update_set(update_set),
    .update_way(update_way), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   set;
    logic [1:0]   way;
    logic [25:0]  tag;
    logic [127:0] data;
  } fill_t;

  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  int compared = 0;
  int mismatched = 0;
  logic [1:0]  exp_vset[$];
  logic [31:0] exp_maddr[$];
  fill_t       exp_fill[$];
  fill_t       f;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: output strobe seen with no expectation queued", name);
  endtask

  // monitor: pops expectations whenever the DUT presents a request or a fill
  always @(negedge clock) begin
    if (!reset) begin
      prev_wait = 1'b0;
    end else begin
      if (victim_req) begin
        if (exp_vset.size() == 0) unexpected("victim_req");
        else check("victim_set", victim_set, exp_vset.pop_front());
      end
      if (mem_req_valid && prev_wait) check("mem_addr_stable", mem_req_addr, prev_addr);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_maddr.size() == 0) unexpected("mem_req");
        else check("mem_req_addr", mem_req_addr, exp_maddr.pop_front());
      end
      prev_wait = mem_req_valid && !mem_req_ready;
      prev_addr = mem_req_addr;
      if (fill_valid || update_req) begin
        if (exp_fill.size() == 0) unexpected("fill");
        else begin
          f = exp_fill.pop_front();
          check("fill_set", fill_set, f.set);
          check("fill_way", fill_way, f.way);
          check("fill_tag", fill_tag, f.tag);
          check("fill_data", fill_data, f.data);
          check("update_req", update_req, 1);
          check("update_set", update_set, f.set);
          check("update_way", update_way, f.way);
        end
      end
    end
  end

  task automatic run_miss(input logic [31:0] a, input logic [3:0] mask, input logic [1:0] vw,
                          input logic [127:0] d, input int delay, input bit junk,
                          input logic [1:0] eset, input logic [1:0] eway,
                          input logic [25:0] etag, input logic [31:0] emaddr);
    if (junk) begin
      @(posedge clock); #1;
      mem_rsp_valid = 1'b1; mem_rsp_data = JUNK;
      @(posedge clock); #1;
      mem_rsp_valid = 1'b0;
    end
    @(negedge clock);
    check("miss_ready_idle", miss_ready, 1);
    @(posedge clock); #1;
    miss_valid = 1'b1; miss_addr = a;
    exp_vset.push_back(eset);
    exp_maddr.push_back(emaddr);
    @(posedge clock); #1;
    miss_valid = 1'b0; set_valid_mask = mask; victim_way = vw;
    @(negedge clock);
    check("victim_req_t1", victim_req, 1);
    @(posedge clock); #1;
    set_valid_mask = ~mask; victim_way = ~vw;
    for (int i = 0; i < delay; i++) begin
      mem_req_ready = 1'b0; miss_valid = 1'b1; miss_addr = 32'hFFFF_FFF0;
      @(negedge clock);
      check("miss_ready_busy", miss_ready, 0);
      @(posedge clock); #1;
    end
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    if (junk) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = JUNK;
    end
    @(negedge clock);
    check("mem_req_valid", mem_req_valid, 1);
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = d;
    exp_fill.push_back('{set: eset, way: eway, tag: etag, data: d});
    @(negedge clock);
    check("mem_req_dropped", mem_req_valid, 0);
    @(posedge clock); #1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clock);
    check("fill_timing", fill_valid, 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("fill_one_cycle", fill_valid, 0);
    check("miss_ready_after", miss_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("busy_in_reset", busy, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_ready", miss_ready, 1);
      check("idle_outs", {victim_req, victim_set, mem_req_valid, mem_req_addr, fill_valid,
                          fill_set, fill_way, fill_tag, update_req, update_set, update_way, busy}, 0);
      check("idle_fill_data", fill_data, 0);
    end
    run_miss(32'h0000_1234, 4'b1111, 2'd2, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
             0, 1'b0, 2'd3, 2'd2, 26'h48, 32'h0000_1230);
    run_miss(32'h0000_5678, 4'b1010, 2'd3, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
             0, 1'b0, 2'd3, 2'd0, 26'h159, 32'h0000_5670);
    run_miss(32'hABCD_EF40, 4'b1011, 2'd1, 128'hCAFE_F00D_0123_4567_89AB_CDEF_FEDC_BA98,
             0, 1'b0, 2'd0, 2'd2, 26'h2AF37BD, 32'hABCD_EF40);
    run_miss(32'h0000_0098, 4'b1111, 2'd1, 128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0,
             5, 1'b0, 2'd1, 2'd1, 26'h2, 32'h0000_0090);
    run_miss(32'h0000_1234, 4'b1111, 2'd0, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA,
             0, 1'b1, 2'd3, 2'd0, 26'h48, 32'h0000_1230);
    // abort a refill while it waits for memory
    @(posedge clock); #1;
    miss_valid = 1'b1; miss_addr = 32'h0000_0470;
    exp_vset.push_back(2'd3);
    exp_maddr.push_back(32'h0000_0470);
    @(posedge clock); #1;
    miss_valid = 1'b0; set_valid_mask = 4'b1111; victim_way = 2'd3;
    @(posedge clock); #1;
    mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    @(negedge clock);
    check("wait_busy", busy, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_ready", miss_ready, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = JUNK;
    @(posedge clock); #1;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("abort_no_fill", {fill_valid, update_req, busy}, 0);
      check("abort_idle_ready", miss_ready, 1);
    end
    check("pending_fills", exp_fill.size(), 0);
    check("pending_victims", exp_vset.size(), 0);
    check("pending_mem_reqs", exp_maddr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
